// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module      : instr_fetch_unit
// Description : Fetch stage. Owns the PC, issues in-order word requests to
//               instruction memory, buffers returned words with their PCs and
//               hands them to decode. A redirect replaces the PC, empties the
//               buffer and discards responses to requests already in flight.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               DEPTH    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [31:0]      imem_rsp_data,
  output logic             inst_valid,
  input  logic             inst_ready,
  output logic [31:0]      inst_data,
  output logic [WIDTH-1:0] inst_pc,
  output logic             misalign_err
);

  localparam int             PW      = $clog2(DEPTH);
  localparam int             CW      = $clog2(DEPTH + 1);
  localparam logic [CW:0]    DEPTH_C = (CW + 1)'(DEPTH);

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  pc_q, pc_d;
  logic [CW-1:0]     out_cnt_q, out_cnt_d;
  logic [CW-1:0]     drop_q, drop_d;
  logic [CW-1:0]     buf_cnt_q, buf_cnt_d;
  logic [PW-1:0]     buf_rd_q, buf_rd_d, buf_wr_q, buf_wr_d;
  logic [PW-1:0]     aq_rd_q, aq_rd_d, aq_wr_q, aq_wr_d;
  logic [WIDTH-1:0]  buf_pc_q   [DEPTH];
  logic [31:0]       buf_data_q [DEPTH];
  logic [WIDTH-1:0]  aq_q       [DEPTH];
  logic              misalign_q;

  logic              credit;
  logic              req_hs;
  logic              inst_hs;
  logic              rsp_keep;
  logic [CW-1:0]     inflight;

  // A request slot exists only while issued-but-unreturned plus buffered
  // words leave room in the buffer; this is what keeps the buffer from ever
  // overflowing. Held low during reset so nothing can be handshaken then.
  assign credit         = (state_q == FETCH) &&
                          (({1'b0, out_cnt_q} + {1'b0, buf_cnt_q}) < DEPTH_C);
  assign imem_req_valid = !rst && credit;
  assign imem_req_addr  = pc_q;
  assign req_hs         = imem_req_valid && imem_req_ready;

  assign inst_valid     = (buf_cnt_q != '0);
  assign inst_data      = buf_data_q[buf_rd_q];
  assign inst_pc        = buf_pc_q[buf_rd_q];
  assign inst_hs        = inst_valid && inst_ready;
  assign misalign_err   = misalign_q;

  // A response is kept only when it belongs to the current fetch stream.
  assign rsp_keep       = imem_rsp_valid && (state_q == FETCH) && !redirect_valid;

  // Requests still owed a response once this cycle's events have happened.
  assign inflight       = out_cnt_q + CW'(req_hs) - CW'(imem_rsp_valid);

  // FSM next state: redirect arms the drop counter, FLUSH waits it out.
  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    if (redirect_valid) begin
      drop_d  = inflight;
      state_d = (inflight != '0) ? FLUSH : FETCH;
    end else if ((state_q == FLUSH) && imem_rsp_valid) begin
      drop_d = drop_q - CW'(1);
      if (drop_q == CW'(1)) begin
        state_d = FETCH;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  // Next PC, counters and queue pointers; redirect overrides everything.
  always_comb begin
    pc_d      = pc_q;
    out_cnt_d = inflight;
    buf_cnt_d = buf_cnt_q + CW'(rsp_keep) - CW'(inst_hs);
    buf_wr_d  = buf_wr_q + PW'(rsp_keep);
    buf_rd_d  = buf_rd_q + PW'(inst_hs);
    aq_wr_d   = aq_wr_q + PW'(req_hs);
    aq_rd_d   = aq_rd_q + PW'(rsp_keep);
    if (req_hs) begin
      pc_d = pc_q + WIDTH'(4);
    end
    if (redirect_valid) begin
      pc_d      = {redirect_pc[WIDTH-1:2], 2'b00};
      buf_cnt_d = '0;
      buf_wr_d  = '0;
      buf_rd_d  = '0;
      aq_wr_d   = '0;
      aq_rd_d   = '0;
    end
  end

  // Datapath registers, address queue and instruction buffer storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      out_cnt_q  <= '0;
      buf_cnt_q  <= '0;
      buf_wr_q   <= '0;
      buf_rd_q   <= '0;
      aq_wr_q    <= '0;
      aq_rd_q    <= '0;
      misalign_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_pc_q[i]   <= '0;
        buf_data_q[i] <= '0;
        aq_q[i]       <= '0;
      end
    end else begin
      pc_q       <= pc_d;
      out_cnt_q  <= out_cnt_d;
      buf_cnt_q  <= buf_cnt_d;
      buf_wr_q   <= buf_wr_d;
      buf_rd_q   <= buf_rd_d;
      aq_wr_q    <= aq_wr_d;
      aq_rd_q    <= aq_rd_d;
      misalign_q <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      if (req_hs) begin
        aq_q[aq_wr_q] <= pc_q;
      end
      if (rsp_keep) begin
        buf_pc_q[buf_wr_q]   <= aq_q[aq_rd_q];
        buf_data_q[buf_wr_q] <= imem_rsp_data;
      end
    end
  end

endmodule

`default_nettype wire
